// File: rtl/ifetch_pkg.sv
// rtl/ifetch_pkg.sv - shared types and default constants for the instruction-fetch controller
package ifetch_pkg;

  localparam int                IFETCH_N        = 32;
  localparam int                IFETCH_R        = 6;
  localparam int                IFETCH_DEPTH    = 4;
  localparam logic [IFETCH_N-1:0] IFETCH_RESET_PC = '0;
  localparam int                PC_STEP         = 4;

  typedef struct packed {
    logic [IFETCH_N-1:0] pc;
    logic [IFETCH_N-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - circular buffer of fetched {pc, instr} entries toward decode
// Flush has priority over push/pop; the caller never pops empty or pushes full without a pop.
module fetch_fifo
  import ifetch_pkg::*;
#(
  parameter int  DEPTH   = IFETCH_DEPTH,
  parameter type entry_t = fetch_entry_t,
  localparam int AW      = $clog2(DEPTH),
  localparam int CW      = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  entry_t        push_entry,
  input  logic          pop,
  input  logic          flush,
  output entry_t        head_entry,
  output logic [CW-1:0] count
);

  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        mem_d[tail_q] = push_entry;
        tail_d        = tail_q + 1'b1;
      end
      if (pop) begin
        head_d = head_q + 1'b1;
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

  assign head_entry = mem_q[head_q];
  assign count      = count_q;

endmodule

// File: rtl/ifetch_ctrl.sv
// rtl/ifetch_ctrl.sv - program counter, fetch/redirect priority and output masking toward decode
// Optional performance counters are built when IFETCH_PERF_EN is defined.
module ifetch_ctrl
  import ifetch_pkg::*;
#(
  parameter int          N        = IFETCH_N,
  parameter int          R        = IFETCH_R,
  parameter int          DEPTH    = IFETCH_DEPTH,
  parameter logic [N-1:0] RESET_PC = N'(IFETCH_RESET_PC)
) (
  input  logic         clk,
  input  logic         reset,
  output logic [R-1:0] imem_addr,
  input  logic [N-1:0] imem_data,
  input  logic         redirect,
  input  logic [N-1:0] redirect_pc,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_instr,
  output logic [N-1:0] out_pc
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]  perf_fetched,
  output logic [31:0]  perf_stalls
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  // Same layout as fetch_entry_t, but sized by this instance's N.
  typedef struct packed {
    logic [N-1:0] pc;
    logic [N-1:0] instr;
  } entry_t;

  logic [N-1:0]  pc_q, pc_d;
  logic          deq;
  logic          fetch;
  entry_t        push_entry;
  entry_t        head_entry;
  logic [CW-1:0] count;

  assign out_valid = (count != '0);
  assign deq       = out_valid && out_ready;
  assign fetch     = !redirect && ((count < CW'(DEPTH)) || deq);

  always_comb begin
    pc_d             = pc_q;
    push_entry.pc    = pc_q;
    push_entry.instr = imem_data;
    if (redirect) begin
      pc_d = {redirect_pc[N-1:2], 2'b00};
    end else if (fetch) begin
      pc_d = pc_q + N'(PC_STEP);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (fetch),
    .push_entry (push_entry),
    .pop        (deq && !redirect),
    .flush      (redirect),
    .head_entry (head_entry),
    .count      (count)
  );

  assign imem_addr = pc_q[R+1:2];
  assign out_instr = out_valid ? head_entry.instr : '0;
  assign out_pc    = out_valid ? head_entry.pc    : '0;

`ifdef IFETCH_PERF_EN
  logic [31:0] fetched_q, fetched_d;
  logic [31:0] stalls_q, stalls_d;

  always_comb begin
    fetched_d = fetched_q + 32'(fetch);
    stalls_d  = stalls_q + 32'(out_valid && !out_ready);
  end

  // Redirect deliberately leaves these running.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetched_q <= '0;
      stalls_q  <= '0;
    end else begin
      fetched_q <= fetched_d;
      stalls_q  <= stalls_d;
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_stalls  = stalls_q;
`endif

endmodule

// File: tb/tb_ifetch_ctrl.sv
// tb/tb_ifetch_ctrl.sv - self-checking bench for ifetch_ctrl with a queue-based reference model
module tb_ifetch_ctrl;

  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic [5:0]  imem_addr;
  logic [31:0] imem_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stalls;
`endif

  logic [31:0] mem [64];
  assign imem_data = mem[imem_addr];

  ifetch_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_pc      (out_pc)
`ifdef IFETCH_PERF_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_stalls  (perf_stalls)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ment_t;

  ment_t       mq[$];
  logic [31:0] mpc;
  logic [31:0] m_fetched;
  logic [31:0] m_stalls;
  int          errors;
  int          checks;

  // Drive one cycle of inputs, advance the reference model, then land 1 time unit after the edge.
  task automatic step(input logic rst, input logic red, input logic [31:0] rpc, input logic rdy);
    ment_t e;
    int    sz;
    reset       = rst;
    redirect    = red;
    redirect_pc = rpc;
    out_ready   = rdy;
    sz = mq.size();
    if (rst) begin
      mq.delete();
      mpc       = 32'h0;
      m_fetched = 0;
      m_stalls  = 0;
    end else begin
      if (sz > 0 && !rdy) m_stalls++;
      if (red) begin
        mq.delete();
        mpc = {rpc[31:2], 2'b00};
      end else begin
        if (sz > 0 && rdy) void'(mq.pop_front());
        if (mq.size() < DEPTH) begin
          e.pc    = mpc;
          e.instr = mem[mpc[7:2]];
          mq.push_back(e);
          mpc = mpc + 32'd4;
          m_fetched++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b1);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h want=0", out_pc); end
    checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL reset_instr got=%h want=0", out_instr); end
    checks++; if (imem_addr !== 6'd0) begin errors++; $display("FAIL reset_addr got=%0d want=0", imem_addr); end
  endtask

  task automatic test_first_fetch();
    do_reset();
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1);
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'(4 * k) || out_instr !== 32'(32'h1000 + k)) begin
        errors++;
        $display("FAIL first_fetch k=%0d got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h",
                 k, out_valid, out_pc, out_instr, 32'(4 * k), 32'(32'h1000 + k));
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
    checks++; if (imem_addr !== 6'd4) begin errors++; $display("FAIL bp_addr got=%0d want=4", imem_addr); end
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin errors++; $display("FAIL bp_head got v=%b pc=%h want v=1 pc=0", out_valid, out_pc); end
    for (int j = 0; j < 5; j++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1);
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'(4 * (j + 1)) || out_instr !== 32'(32'h1001 + j)) begin
        errors++;
        $display("FAIL bp_drain j=%0d got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h",
                 j, out_valid, out_pc, out_instr, 32'(4 * (j + 1)), 32'(32'h1001 + j));
      end
    end
  endtask

  task automatic test_redirect();
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 32'h20, 1'b0);
    checks++; if (out_valid !== 1'b0 || out_pc !== 32'h0) begin errors++; $display("FAIL redir_bubble got v=%b pc=%h want v=0 pc=0", out_valid, out_pc); end
    checks++; if (imem_addr !== 6'd8) begin errors++; $display("FAIL redir_addr got=%0d want=8", imem_addr); end
    step(1'b0, 1'b0, 32'h0, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h20 || out_instr !== 32'h1008) begin
      errors++;
      $display("FAIL redir_target got v=%b pc=%h instr=%h want v=1 pc=20 instr=1008", out_valid, out_pc, out_instr);
    end
  endtask

  task automatic test_misaligned_wrap();
    do_reset();
    step(1'b0, 1'b1, 32'h23, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    checks++; if (out_pc !== 32'h20 || out_instr !== 32'h1008) begin errors++; $display("FAIL misalign got pc=%h instr=%h want pc=20 instr=1008", out_pc, out_instr); end
    step(1'b0, 1'b1, 32'hFC, 1'b1);
    checks++; if (imem_addr !== 6'd63) begin errors++; $display("FAIL wrap_addr63 got=%0d want=63", imem_addr); end
    step(1'b0, 1'b0, 32'h0, 1'b1);
    checks++; if (imem_addr !== 6'd0) begin errors++; $display("FAIL wrap_addr0 got=%0d want=0", imem_addr); end
    checks++; if (out_pc !== 32'hFC || out_instr !== 32'h103F) begin errors++; $display("FAIL wrap_fc got pc=%h instr=%h want pc=fc instr=103f", out_pc, out_instr); end
    step(1'b0, 1'b0, 32'h0, 1'b1);
    checks++; if (out_pc !== 32'h100 || out_instr !== 32'h1000) begin errors++; $display("FAIL wrap_100 got pc=%h instr=%h want pc=100 instr=1000", out_pc, out_instr); end
  endtask

  task automatic test_reset_over_redirect();
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b1, 32'h40, 1'b0);
    checks++; if (out_valid !== 1'b0 || imem_addr !== 6'd0) begin errors++; $display("FAIL rst_redir got v=%b addr=%0d want v=0 addr=0", out_valid, imem_addr); end
    step(1'b0, 1'b0, 32'h0, 1'b1);
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin errors++; $display("FAIL rst_redir_restart got v=%b pc=%h want v=1 pc=0", out_valid, out_pc); end
  endtask

`ifdef IFETCH_PERF_EN
  task automatic test_perf();
    do_reset();
    checks++; if (perf_fetched !== 32'd0 || perf_stalls !== 32'd0) begin errors++; $display("FAIL perf_reset got f=%0d s=%0d want 0 0", perf_fetched, perf_stalls); end
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
    checks++; if (perf_stalls !== 32'd4) begin errors++; $display("FAIL perf_stalls got=%0d want=4", perf_stalls); end
    checks++; if (perf_fetched !== 32'd9) begin errors++; $display("FAIL perf_fetched got=%0d want=9", perf_fetched); end
    step(1'b0, 1'b1, 32'h80, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    checks++; if (perf_fetched !== m_fetched || perf_stalls !== m_stalls) begin errors++; $display("FAIL perf_redir got f=%0d s=%0d want f=%0d s=%0d", perf_fetched, perf_stalls, m_fetched, m_stalls); end
  endtask
`endif

  task automatic test_random();
    logic        rst, red, rdy;
    logic [31:0] rpc;
    logic        exp_v;
    logic [31:0] exp_pc, exp_instr;
    for (int k = 0; k < 64; k++) mem[k] = $urandom;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 63) == 0);
      red = ($urandom_range(0, 7) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      rpc = $urandom;
      step(rst, red, rpc, rdy);
      exp_v     = (mq.size() != 0);
      exp_pc    = exp_v ? mq[0].pc : 32'h0;
      exp_instr = exp_v ? mq[0].instr : 32'h0;
      checks++;
      if (out_valid !== exp_v || out_pc !== exp_pc || out_instr !== exp_instr || imem_addr !== mpc[7:2]) begin
        errors++;
        $display("FAIL random n=%0d got v=%b pc=%h instr=%h addr=%0d want v=%b pc=%h instr=%h addr=%0d",
                 n, out_valid, out_pc, out_instr, imem_addr, exp_v, exp_pc, exp_instr, mpc[7:2]);
      end
`ifdef IFETCH_PERF_EN
      checks++;
      if (perf_fetched !== m_fetched || perf_stalls !== m_stalls) begin
        errors++;
        $display("FAIL random_perf n=%0d got f=%0d s=%0d want f=%0d s=%0d", n, perf_fetched, perf_stalls, m_fetched, m_stalls);
      end
`endif
    end
  endtask

  initial begin
    clk         = 1'b0;
    reset       = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    out_ready   = 1'b0;
    errors      = 0;
    checks      = 0;
    mpc         = 32'h0;
    m_fetched   = 0;
    m_stalls    = 0;
    for (int k = 0; k < 64; k++) mem[k] = 32'h1000 + 32'(k);
    @(posedge clk);
    #1;
    test_reset();
    test_first_fetch();
    test_backpressure();
    test_redirect();
    test_misaligned_wrap();
    test_reset_over_redirect();
`ifdef IFETCH_PERF_EN
    test_perf();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
